// File: rtl/shift_pattern_checker.sv
// rtl/shift_pattern_checker.sv - lock/track monitor for the bouncing one-hot shift pattern
// Hunts for the 0x01->0x02 edge, then follows the period and flags samples that break it.
module shift_pattern_checker #(
  parameter int DWELL     = 4,
  parameter int LOCK_LOSS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pattern,
  input  logic       pattern_valid,
  output logic       locked,
  output logic [4:0] step,
  output logic       direction,
  output logic [2:0] bit_pos,
  output logic       onehot_err,
  output logic       seq_err,
  output logic [7:0] err_count
);
  localparam logic [4:0] LAST_STEP = 5'(DWELL + 13);
  localparam logic [4:0] WALK_L    = 5'(DWELL);
  localparam logic [4:0] WALK_R    = 5'(DWELL + 7);
  localparam logic [3:0] MISS_MAX  = 4'(LOCK_LOSS);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t     state;
  logic       prev_ok;
  logic [3:0] miss;
  logic [4:0] next_step;
  logic [7:0] exp_pat;
  logic       is_onehot;
  logic [2:0] pos;

  always_comb begin
    next_step = (step == LAST_STEP) ? 5'd0 : step + 5'd1;
    if (next_step < WALK_L)
      exp_pat = 8'h01;
    else if (next_step < WALK_R)
      exp_pat = 8'h02 << 3'(next_step - WALK_L);
    else
      exp_pat = 8'h40 >> 3'(next_step - WALK_R);
  end

  // pos is only meaningful when the sample is one-hot; it is masked below otherwise
  always_comb begin
    is_onehot = (pattern != 8'd0) && ((pattern & (pattern - 8'd1)) == 8'd0);
    pos = 3'd0;
    for (int i = 0; i < 8; i++)
      if (pattern[i]) pos = 3'(i);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= HUNT;
      prev_ok    <= 1'b0;
      miss       <= 4'd0;
      locked     <= 1'b0;
      step       <= 5'd0;
      direction  <= 1'b0;
      bit_pos    <= 3'd0;
      onehot_err <= 1'b0;
      seq_err    <= 1'b0;
      err_count  <= 8'd0;
    end else begin
      seq_err <= 1'b0;
      if (pattern_valid) begin
        bit_pos    <= is_onehot ? pos : 3'd0;
        onehot_err <= !is_onehot;
        case (state)
          HUNT: begin
            prev_ok <= (pattern == 8'h01);
            if (pattern == 8'h02 && prev_ok) begin
              state     <= LOCKED;
              locked    <= 1'b1;
              step      <= WALK_L;
              direction <= 1'b0;
              miss      <= 4'd0;
            end
          end
          LOCKED: begin
            step      <= next_step;
            direction <= (next_step >= WALK_R);
            if (pattern == exp_pat) begin
              miss <= 4'd0;
            end else begin
              seq_err <= 1'b1;
              if (err_count != 8'hff) err_count <= err_count + 8'd1;
              if (miss + 4'd1 >= MISS_MAX) begin
                state     <= HUNT;
                locked    <= 1'b0;
                prev_ok   <= (pattern == 8'h01);
                miss      <= 4'd0;
                step      <= 5'd0;
                direction <= 1'b0;
              end else begin
                miss <= miss + 4'd1;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end
endmodule

// File: doc/shift_pattern_checker.md
Name: shift_pattern_checker

Overview:
Receive-side checker for the 8-bit bouncing one-hot LED pattern produced by the shift counter. The pattern is DWELL cycles of 0x01, then a left walk 0x02..0x80, then a right walk 0x40..0x01. The block acquires lock on the pattern and tracks the sequence step. It decodes the active bit position and direction, and flags and counts any sample that breaks the sequence. It sits on the count bus as a self-check monitor for board bring-up and for the test bench.

Parameters:
DWELL, 4, number of leading 0x01 steps per period; legal 1..18; period P = DWELL+14 steps
LOCK_LOSS, 3, consecutive mismatches in LOCKED that force return to HUNT; legal 1..15

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset; sampled only on rising clk
pattern  input  8  observed pattern sample
pattern_valid  input  1  pattern is a new sample this cycle
locked  output  1  tracker is in LOCKED
step  output  5  current sequence step 0..P-1; valid only when locked=1
direction  output  1  0 = dwell or left walk, 1 = right walk; valid when locked=1
bit_pos  output  3  index of the set bit of the last valid sample; 0 if not one-hot
onehot_err  output  1  last valid sample did not have exactly one bit set
seq_err  output  1  one-cycle pulse: valid sample mismatched the expected value while LOCKED
err_count  output  8  saturating count of seq_err pulses

Behaviour:
- Reset (reset=0 at a rising clk) takes effect at that edge:
  - outputs: locked=0, step=0, direction=0, bit_pos=0, onehot_err=0, seq_err=0, err_count=0
  - internal: state=HUNT, prev_ok=0, miss=0
  - Takes priority over any concurrent sample. Reset mid-operation abandons lock immediately.
- Expected pattern E(s):
  - s<DWELL: 0x01
  - s=DWELL+k, k=0..6: 1<<(k+1)
  - s=DWELL+7+k, k=0..6: 0x40>>k
- direction = 1 iff step >= DWELL+7.
- Registered outputs. All outputs update at the clk edge that samples pattern_valid=1, so latency is 1 cycle.
- When pattern_valid=0: all outputs and state hold, except seq_err, which is 0.
- bit_pos and onehot_err update on every valid sample in every state.
- State HUNT:
  - prev_ok is set when a valid sample equals 0x01 and cleared by any other valid sample.
  - A valid sample of 0x02 with prev_ok=1 gives: state=LOCKED, step=DWELL, locked=1, miss=0.
  - No seq_err or err_count activity in HUNT.
- State LOCKED, on each valid sample:
  - next step n = (step==P-1) ? 0 : step+1; step<=n unconditionally (source assumed free-running).
  - pattern==E(n): miss<=0.
  - Otherwise: seq_err=1 for one cycle, err_count+=1 saturating at 255, miss+=1.
  - If miss+1 reaches LOCK_LOSS: state=HUNT, locked=0, prev_ok=(pattern==0x01), miss=0, step=0.
- Non-one-hot samples (0x00, multi-bit) always mismatch in LOCKED.
- err_count is cleared only by reset; it holds through lock loss and reacquisition.
- Lock is acquired only at the unique 0x01->0x02 transition. A 0x02 seen without a prior 0x01 does not lock.

Test Plan:
- Reset, then a clean sequence from step 0 with DWELL=4 -> locked=1 one cycle after the 5th sample (0x02), step=4; over 3 full periods seq_err stays 0, err_count=0, direction=1 exactly on steps 11..17.
- Locked; inject 0x10 instead of 0x20 at step 8 -> single seq_err pulse, err_count=1, onehot_err=0, bit_pos=4, locked stays 1; the following correct sample (step 9) gives no error.
- Locked; inject 3 consecutive 0x00 -> onehot_err=1 and bit_pos=0 on each, err_count=3, locked=0 after the third; resume the clean stream -> relock at the next 0x01->0x02 with step=4.
- pattern_valid asserted every other cycle with the clean stream -> same lock point and step sequence as contiguous; outputs hold and seq_err=0 on invalid cycles.
- reset=0 for one edge while locked at step 12 -> next cycle all outputs zero and locked=0; a reset=0 glitch between edges has no effect.
- DWELL=1, one corrupted sample per period for 260 periods -> locked never drops, err_count saturates at 255 and holds.
